// File: rtl/aes_gcm_pkg.sv
// Shared GCM definitions: phase codes, GF(2^128) reduction constant,
// block type and the GHASH stage FSM encoding.
package aes_gcm_pkg;

   typedef logic [0:127] gcm_block_t;

   localparam logic [0:2] PH_INIT = 3'b000;
   localparam logic [0:2] PH_AAD  = 3'b001;
   localparam logic [0:2] PH_TEXT = 3'b010;
   localparam logic [0:2] PH_LEN  = 3'b011;
   localparam logic [0:2] PH_IDLE = 3'b111;

   localparam gcm_block_t GCM_R = {8'hE1, 120'h0};

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } ghash_state_e;

   function automatic logic phase_is_data(logic [0:2] ph);
      return (ph == PH_AAD) || (ph == PH_TEXT) || (ph == PH_LEN);
   endfunction

endpackage

// File: rtl/gf128_digit_mul.sv
// Combinational DIGIT_BITS-step shift-and-add update of (Z, V)
// for GF(2^128) multiply in SP 800-38D bit ordering.
module gf128_digit_mul
   import aes_gcm_pkg::*;
#(
   parameter int DIGIT_BITS = 8
) (
   input  logic [0:127]            i_z,
   input  logic [0:127]            i_v,
   input  logic [0:DIGIT_BITS-1]   i_digit,
   output logic [0:127]            o_z,
   output logic [0:127]            o_v
);

   logic [0:127] w_z;
   logic [0:127] w_v;

   // Bit 0 of the digit is the lowest-order Hq bit of this step.
   always_comb begin
      w_z = i_z;
      w_v = i_v;
      for (int b = 0; b < DIGIT_BITS; b++) begin
         if (i_digit[b]) w_z = w_z ^ w_v;
         w_v = (w_v >> 1) ^ (w_v[127] ? GCM_R : '0);
      end
   end

   assign o_z = w_z;
   assign o_v = w_v;

endmodule

// File: rtl/aes_ghash_stage.sv
// Digit-serial GHASH accumulator; folds one block per S+1 cycles
// and emits the GCM tag after the length block.
module aes_ghash_stage
   import aes_gcm_pkg::*;
#(
   parameter int DIGIT_BITS = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_valid,
   input  logic [0:127]   i_block,
   input  logic [0:2]     i_phase,
   input  logic           i_new_instance,
   input  logic [0:127]   i_h,
   input  logic [0:127]   i_ek_j0,
   output logic           o_ready,
   output logic           o_valid,
   output logic [0:127]   o_y,
   output logic           o_tag_valid,
   output logic [0:127]   o_tag
);

   localparam int         S    = 128 / DIGIT_BITS;
   localparam logic [7:0] LAST = 8'(S - 1);

   ghash_state_e r_state;
   ghash_state_e w_next;

   logic [0:127] r_h;
   logic [0:127] r_ekj0;
   logic [0:127] r_v;
   logic [0:127] r_z;
   logic [0:127] r_hq;
   logic [0:127] r_y;
   logic [0:127] r_tag;
   logic [0:2]   r_phase;
   logic [7:0]   r_cnt;
   logic         r_valid;
   logic         r_tag_valid;

   logic [0:127] w_z;
   logic [0:127] w_v;
   logic         w_accept;
   logic         w_last;

   assign w_accept = i_valid && (r_state == ST_IDLE)
                     && phase_is_data(i_phase);
   assign w_last   = (r_state == ST_BUSY) && (r_cnt == LAST);

   gf128_digit_mul #(
      .DIGIT_BITS (DIGIT_BITS)
   ) u_mul (
      .i_z     (r_z),
      .i_v     (r_v),
      .i_digit (r_hq[0:DIGIT_BITS-1]),
      .o_z     (w_z),
      .o_v     (w_v)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (w_accept) w_next = ST_BUSY;
         ST_BUSY: if (w_last)   w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h         <= '0;
         r_ekj0      <= '0;
         r_v         <= '0;
         r_z         <= '0;
         r_hq        <= '0;
         r_y         <= '0;
         r_tag       <= '0;
         r_phase     <= PH_INIT;
         r_cnt       <= '0;
         r_valid     <= 1'b0;
         r_tag_valid <= 1'b0;
      end else begin
         r_valid     <= 1'b0;
         r_tag_valid <= 1'b0;
         if (w_accept) begin
            if (i_new_instance) begin
               r_h    <= i_h;
               r_ekj0 <= i_ek_j0;
            end
            r_v     <= (i_new_instance ? '0 : r_y) ^ i_block;
            r_z     <= '0;
            r_hq    <= i_new_instance ? i_h : r_h;
            r_cnt   <= '0;
            r_phase <= i_phase;
         end else if (r_state == ST_BUSY) begin
            r_v   <= w_v;
            r_z   <= w_z;
            r_hq  <= r_hq << DIGIT_BITS;
            r_cnt <= r_cnt + 8'd1;
            if (w_last) begin
               r_y     <= w_z;
               r_valid <= 1'b1;
               if (r_phase == PH_LEN) begin
                  r_tag       <= r_ekj0 ^ w_z;
                  r_tag_valid <= 1'b1;
               end
            end
         end
      end
   end

   assign o_ready     = (r_state == ST_IDLE);
   assign o_valid     = r_valid;
   assign o_y         = r_y;
   assign o_tag_valid = r_tag_valid;
   assign o_tag       = r_tag;

endmodule

// File: tb/tb_aes_ghash_stage.sv
// Directed and random checks of aes_ghash_stage against a
// carry-less-multiply GHASH model.
module tb_aes_ghash_stage;
   import aes_gcm_pkg::*;

   typedef logic [0:127] blk_t;

   localparam blk_t H0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam blk_t EK0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
   localparam blk_t C0  = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam blk_t Y1  = 128'h5e2ec746917062882c85b0685353deb7;
   localparam blk_t L0  = 128'h00000000000000000000000000000080;
   localparam blk_t T1  = 128'hab6e47d42cec13bdf53a67b21257bddf;
   localparam blk_t ONE = 128'h80000000000000000000000000000000;
   localparam blk_t XID = 128'h0123456789abcdeffedcba9876543210;

   logic clk = 1'b0;
   logic rst;
   logic i_valid;
   blk_t i_block;
   logic [0:2] i_phase;
   logic i_new_instance;
   blk_t i_h;
   blk_t i_ek_j0;

   logic rdy8, v8, tv8;
   blk_t y8, tag8;
   logic rdy1, v1, tv1;
   blk_t y1, tag1;
   logic rdy32, v32, tv32;
   blk_t y32, tag32;

   int errors = 0;
   int checks = 0;

   blk_t m_y, m_h, m_ek;

   always #5 clk = ~clk;

   aes_ghash_stage #(.DIGIT_BITS(8)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_block(i_block),
      .i_phase(i_phase), .i_new_instance(i_new_instance),
      .i_h(i_h), .i_ek_j0(i_ek_j0), .o_ready(rdy8), .o_valid(v8),
      .o_y(y8), .o_tag_valid(tv8), .o_tag(tag8));

   aes_ghash_stage #(.DIGIT_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_block(i_block),
      .i_phase(i_phase), .i_new_instance(i_new_instance),
      .i_h(i_h), .i_ek_j0(i_ek_j0), .o_ready(rdy1), .o_valid(v1),
      .o_y(y1), .o_tag_valid(tv1), .o_tag(tag1));

   aes_ghash_stage #(.DIGIT_BITS(32)) dut32 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_block(i_block),
      .i_phase(i_phase), .i_new_instance(i_new_instance),
      .i_h(i_h), .i_ek_j0(i_ek_j0), .o_ready(rdy32), .o_valid(v32),
      .o_y(y32), .o_tag_valid(tv32), .o_tag(tag32));

   // Bit i of a block is the coefficient of x^i.
   function automatic blk_t gmul(blk_t a, blk_t b);
      logic [254:0] p;
      blk_t r;
      p = '0;
      for (int i = 0; i < 128; i++)
         if (a[i])
            for (int j = 0; j < 128; j++)
               if (b[j]) p[i+j] = ~p[i+j];
      for (int k = 254; k >= 128; k--)
         if (p[k]) begin
            p[k]     = 1'b0;
            p[k-128] = ~p[k-128];
            p[k-127] = ~p[k-127];
            p[k-126] = ~p[k-126];
            p[k-121] = ~p[k-121];
         end
      for (int i = 0; i < 128; i++) r[i] = p[i];
      return r;
   endfunction

   function automatic blk_t rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_step(blk_t x, logic nw, blk_t h, blk_t ek);
      if (nw) begin
         m_h  = h;
         m_ek = ek;
         m_y  = '0;
      end
      m_y = gmul(m_y ^ x, m_h);
   endtask

   task automatic chk(string tag, blk_t obs, blk_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(blk_t x, logic [0:2] ph, logic nw,
                       blk_t h, blk_t ek);
      int n;
      n = 0;
      while (!rdy8 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 400) chk("ready_timeout", 128'(rdy8), 128'(1));
      i_valid        = 1'b1;
      i_block        = x;
      i_phase        = ph;
      i_new_instance = nw;
      i_h            = h;
      i_ek_j0        = ek;
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_out(string tag, int lat);
      int c;
      c = 0;
      do begin
         @(posedge clk); #1;
         c++;
      end while (!v8 && c < 400);
      chk({tag, "_lat"}, 128'(c), 128'(lat));
   endtask

   initial begin
      int seen;
      int lat8, lat1, lat32;
      blk_t cy8, cy1, cy32;
      blk_t h, ek, x;
      logic first;

      rst = 1'b1;
      i_valid = 1'b0;
      i_block = '0;
      i_phase = PH_INIT;
      i_new_instance = 1'b0;
      i_h = '0;
      i_ek_j0 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 128'(rdy8), 128'(1));
      chk("rst_valid", 128'(v8), 128'(0));
      chk("rst_tagv", 128'(tv8), 128'(0));
      chk("rst_y", y8, '0);
      chk("rst_tag", tag8, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      send('0, PH_LEN, 1'b1, H0, EK0);
      model_step('0, 1'b1, H0, EK0);
      wait_out("empty", 16);
      chk("empty_y", y8, '0);
      chk("empty_tag", tag8, EK0);
      chk("empty_tagv", 128'(tv8), 128'(1));
      @(posedge clk); #1;
      chk("empty_pulse", 128'({v8, tv8}), 128'(0));

      send(C0, PH_TEXT, 1'b1, H0, EK0);
      model_step(C0, 1'b1, H0, EK0);
      wait_out("single", 16);
      chk("single_y", y8, Y1);
      chk("single_model", y8, m_y);
      chk("single_tagv", 128'(tv8), 128'(0));
      send(L0, PH_LEN, 1'b0, '0, '0);
      model_step(L0, 1'b0, '0, '0);
      wait_out("len", 16);
      chk("len_tag", tag8, T1);
      chk("len_model", tag8, m_ek ^ m_y);

      // Upstream keeps i_valid high while the block is in flight.
      i_valid = 1'b1;
      i_block = C0;
      i_phase = PH_TEXT;
      i_new_instance = 1'b1;
      i_h = H0;
      i_ek_j0 = EK0;
      @(posedge clk); #1;
      i_block = ~C0;
      i_h = ~H0;
      wait_out("drop", 16);
      i_valid = 1'b0;
      chk("drop_y", y8, Y1);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (v8) seen++;
      end
      chk("drop_pulses", 128'(seen), 128'(0));
      chk("drop_y_hold", y8, Y1);

      send(L0, PH_LEN, 1'b0, '0, '0);
      wait_out("drop_len", 16);
      chk("drop_tag", tag8, T1);
      send(C0, PH_TEXT, 1'b1, H0, EK0);
      wait_out("clr", 16);
      chk("clr_y", y8, Y1);
      send(L0, PH_LEN, 1'b0, '0, '0);
      wait_out("clr_len", 16);
      chk("clr_tag", tag8, T1);

      i_valid = 1'b1;
      i_phase = PH_IDLE;
      i_block = C0;
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk("idle_ready", 128'(rdy8), 128'(1));
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (v8 || !rdy8) seen++;
      end
      chk("idle_ignored", 128'(seen), 128'(0));

      send(C0, PH_TEXT, 1'b1, H0, EK0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_ready", 128'(rdy8), 128'(1));
      chk("mid_y", y8, '0);
      chk("mid_valid", 128'(v8), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (v8) seen++;
      end
      chk("mid_no_valid", 128'(seen), 128'(0));
      send('0, PH_LEN, 1'b1, H0, EK0);
      wait_out("mid_empty", 16);
      chk("mid_empty_tag", tag8, EK0);

      for (int m = 0; m < 6; m++) begin
         int nb;
         h  = rnd128();
         ek = rnd128();
         nb = $urandom_range(0, 3);
         first = 1'b1;
         for (int b = 0; b < nb; b++) begin
            x = rnd128();
            send(x, ($urandom_range(0, 1) == 0) ? PH_AAD : PH_TEXT,
                 first, h, ek);
            model_step(x, first, h, ek);
            first = 1'b0;
            wait_out("rnd_blk", 16);
            chk("rnd_y", y8, m_y);
            chk("rnd_no_tag", 128'(tv8), 128'(0));
         end
         x = rnd128();
         send(x, PH_LEN, first, h, ek);
         model_step(x, first, h, ek);
         wait_out("rnd_len", 16);
         chk("rnd_len_y", y8, m_y);
         chk("rnd_tag", tag8, m_ek ^ m_y);
      end

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      i_valid = 1'b1;
      i_block = XID;
      i_phase = PH_TEXT;
      i_new_instance = 1'b1;
      i_h = ONE;
      i_ek_j0 = '0;
      @(posedge clk); #1;
      i_valid = 1'b0;
      lat8 = -1;
      lat1 = -1;
      lat32 = -1;
      cy8 = '0;
      cy1 = '0;
      cy32 = '0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (v8 && lat8 < 0) begin lat8 = c; cy8 = y8; end
         if (v1 && lat1 < 0) begin lat1 = c; cy1 = y1; end
         if (v32 && lat32 < 0) begin lat32 = c; cy32 = y32; end
      end
      chk("id8_lat", 128'(lat8), 128'(16));
      chk("id1_lat", 128'(lat1), 128'(128));
      chk("id32_lat", 128'(lat32), 128'(4));
      chk("id8_y", cy8, XID);
      chk("id1_y", cy1, XID);
      chk("id32_y", cy32, XID);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
